// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, ack check.
// Latency: INHIBIT_CYCLES + 1 cycles to RTS; each data change lands within SYNC_STAGES+1 cycles of a device clock fall.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored. Optional retry: PS2_HOST_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RTS     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             state_q, state_d;
  logic [7:0]             data_q, data_d;
  logic                   parity_q, parity_d;
  logic [IW-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   dat_oe_q, dat_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  logic clk_s, dat_s, fe, nack, tmo;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fe    = clk_prev_q & ~clk_s;

  // Shift the asynchronous pin senses through the synchronizer chains
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_in};
    clk_prev_d = clk_s;
  end

  // Transaction FSM: next state, counters and registered line/status outputs
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    nack      = 1'b0;
    tmo       = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    // Watchdog from RTS onward; any device clock fall restarts it, so a fall beats a timeout
    if (state_q == S_RTS || state_q == S_SEND || state_q == S_ACK || state_q == S_RELEASE) begin
      if (fe) begin
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
        tmo      = (to_cnt_q == TO_LAST);
      end
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          data_d    = cmd_data;
          parity_d  = ~^cmd_data;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          dat_oe_d  = (INHIBIT_CYCLES == 1);
          state_d   = S_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retry_d   = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes down during the final inhibit cycle so RTS follows cleanly
        if (inh_cnt_q == INH_PRE) dat_oe_d = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          state_d   = S_RTS;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b1;
        bitcnt_d = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          if (bitcnt_q < 4'd8)       dat_oe_d = ~data_q[bitcnt_q[2:0]];
          else if (bitcnt_q == 4'd8) dat_oe_d = ~parity_q;
          else                       dat_oe_d = 1'b0;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fe) begin
          if (!dat_s) state_d = S_RELEASE;
          else        nack    = 1'b1;
        end
      end
      S_RELEASE: begin
        if (clk_s && dat_s) begin
          done_d   = 1'b1;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // Failure: release both lines and report, or start one more attempt with the same byte
    if (nack || (tmo && !done_d)) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      error_d  = 1'b1;
      state_d  = S_IDLE;
`ifdef PS2_HOST_TX_RETRY_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        error_d   = 1'b0;
        inh_cnt_d = '0;
        clk_oe_d  = 1'b1;
        dat_oe_d  = (INHIBIT_CYCLES == 1);
        state_d   = S_INHIBIT;
      end
`endif
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset; synchronizers reset to idle-high lines
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      data_q      <= '0;
      parity_q    <= 1'b0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bitcnt_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clk_oe_q    <= 1'b0;
      dat_oe_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      data_q      <= data_d;
      parity_q    <= parity_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bitcnt_q    <= bitcnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_oe_q    <= clk_oe_d;
      dat_oe_q    <= dat_oe_d;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model plus a scaled-down PS/2 device clocking model.
// Timing parameters are shrunk so every scenario fits in a short run.
// Outputs are sampled on the falling edge of CLOCK_50.
module tb_ps2_host_tx;
  localparam int INH  = 40;
  localparam int TO   = 600;
  localparam int SYNC = 2;
  localparam int HALF = 25;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready, busy, done, error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rdy_cnt = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy), .done(done), .error(error),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Wired-AND of host pull-down and device drive
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  // Pulse counters, read by the tests as before/after deltas
  always @(posedge CLOCK_50) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (error === 1'b1) err_cnt = err_cnt + 1;
    if (cmd_ready === 1'b1) rdy_cnt = rdy_cnt + 1;
  end

  task automatic send_cmd(input logic [7:0] b);
    @(negedge CLOCK_50);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
  endtask

  // Device: wait for RTS, then clock npulse bits, sampling dat_oe SYNC+1 cycles after each fall.
  // With npulse==10 an eleventh pulse follows, with data pulled low when ack is set.
  task automatic dev_run(input int npulse, input logic ack, output logic [9:0] bits, output logic ok);
    int n;
    bits = '0;
    ok   = 1'b0;
    n    = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 2000) return;
    ok = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    for (int i = 0; i < npulse; i++) begin
      dev_clk = 1'b0;
      repeat (SYNC + 1) @(negedge CLOCK_50);
      bits[i] = ps2_dat_oe;
      repeat (HALF - SYNC - 1) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
    end
    if (npulse == 10) begin
      dev_dat = ~ack;
      repeat (5) @(negedge CLOCK_50);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
      dev_clk = 1'b1;
      repeat (5) @(negedge CLOCK_50);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
      @(negedge CLOCK_50);
      n++;
    end
    repeat (20) @(negedge CLOCK_50);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic test_send_ed();
    int n, d0, e0;
    logic early, last_dat, ok;
    logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'hED);
    n = 0; early = 1'b0; last_dat = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < 1000) begin
      if (last_dat) early = 1'b1;
      last_dat = ps2_dat_oe;
      n++;
      @(negedge CLOCK_50);
    end
    checks++; if (n != INH) begin errors++; $display("FAIL inhibit_len: got %0d want %0d", n, INH); end
    checks++; if (last_dat !== 1'b1) begin errors++; $display("FAIL inhibit_last_dat: got %b want 1", last_dat); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL inhibit_early_dat: got %b want 0", early); end
    dev_run(10, 1'b1, bits, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ed_rts_seen: got %b want 1", ok); end
    checks++; if (bits !== 10'h012) begin errors++; $display("FAIL ed_bits: got %h want 012", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ed_done: got %0d want 1", done_cnt - d0); end
    checks++; if (err_cnt - e0 != 0) begin errors++; $display("FAIL ed_error: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_send_zero();
    int d0, e0;
    logic ok;
    logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'h00);
    dev_run(10, 1'b1, bits, ok);
    checks++; if (bits !== 10'h0FF) begin errors++; $display("FAIL zero_bits: got %h want 0ff", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_no_ack();
    int d0, e0;
    logic ok;
    logic [9:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    send_cmd(8'hFF);
    for (int r = 0; r < ATTEMPTS; r++) dev_run(10, 1'b0, bits, ok);
    wait_end(d0, e0);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL noack_error: got %0d want 1", err_cnt - e0); end
    checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL noack_done: got %0d want 0", done_cnt - d0); end
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL noack_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL noack_dat_oe: got %b want 0", ps2_dat_oe); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL noack_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_timeout();
    int n;
    send_cmd(8'hF2);
    n = 0;
    for (int r = 0; r < ATTEMPTS; r++) begin
      n = 0;
      while (ps2_clk_oe !== 1'b1 && n < 5000) begin @(negedge CLOCK_50); n++; end
      n = 0;
      while (ps2_clk_oe !== 1'b0 && n < 5000) begin @(negedge CLOCK_50); n++; end
      n = 0;
      while (error !== 1'b1 && ps2_clk_oe !== 1'b1 && n < TO + 50) begin @(negedge CLOCK_50); n++; end
    end
    checks++; if (n != TO || error !== 1'b1) begin errors++; $display("FAIL timeout_delay: got %0d err=%b want %0d err=1", n, error, TO); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL timeout_lines: got clk_oe=%b dat_oe=%b want 0 0", ps2_clk_oe, ps2_dat_oe); end
    @(negedge CLOCK_50);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", cmd_ready); end
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic test_back_to_back();
    int n, r0, d0, e0;
    logic ok;
    logic [9:0] bits;
    @(negedge CLOCK_50);
    cmd_data = 8'hF4; cmd_valid = 1'b1;
    @(negedge CLOCK_50);
    cmd_data = 8'h55;
    r0 = rdy_cnt;
    dev_run(10, 1'b1, bits, ok);
    checks++; if (rdy_cnt - r0 != 0) begin errors++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", rdy_cnt - r0); end
    checks++; if (bits !== 10'h10B) begin errors++; $display("FAIL b2b_f4_bits: got %h want 10b", bits); end
    n = 0;
    while (done !== 1'b1 && n < 500) begin @(negedge CLOCK_50); n++; end
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got ready=%b done=%b want 1 1", cmd_ready, done); end
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got clk_oe=%b busy=%b want 1 1", ps2_clk_oe, busy); end
    d0 = done_cnt; e0 = err_cnt;
    dev_run(10, 1'b1, bits, ok);
    checks++; if (bits !== 10'h0AA) begin errors++; $display("FAIL b2b_55_bits: got %h want 0aa", bits); end
    wait_end(d0, e0);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_55_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    logic ok;
    logic [9:0] bits;
    send_cmd(8'hED);
    dev_run(4, 1'b1, bits, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_rts_seen: got %b want 1", ok); end
    d0 = done_cnt; e0 = err_cnt;
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL mid_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL mid_dat_oe: got %b want 0", ps2_dat_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    repeat (TO + 20) @(negedge CLOCK_50);
    checks++; if (done_cnt != d0 || err_cnt != e0) begin errors++; $display("FAIL mid_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_no_ack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
